sram_req_arbiter: RTL and testbench

SRAM_REQ_ARBITER -- requirements
Module: sram_req_arbiter

---
 rtl/sram_req_arbiter.sv | 147 ++++++++++++++
 tb/tb_sram_req_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter
//   Arbitrates the fetch-side (inst_*) and execute-side (data_*) SRAM-like
//   request ports onto one shared downstream port (dev_*). Requests and
//   responses pass through combinationally. Downstream responses return in
//   acceptance order, so a small owner FIFO records which side each accepted
//   request belongs to. The returned data_ok is routed to that side.
//
// Parameters
//   MAX_OUTST  max accepted-but-unanswered downstream requests (1..4)
//
// Ports
//   clk, reset                     clock, synchronous active-high reset
//   inst_* / data_* (in)           requester valid, write flag, size, strobes,
//                                  address, write data
//   inst_/data_addr_ok, _data_ok   per-requester accept / response strobes
//   inst_/data_rdata               read data (both mirror dev_rdata)
//   dev_* (out)                    shared downstream request
//   dev_addr_ok, dev_data_ok,
//   dev_rdata (in)                 downstream handshake and read data
//   resp_err                       sticky: response seen with nothing outstanding
module sram_req_arbiter #(
    parameter int MAX_OUTST = 2
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        dev_req,
    output logic        dev_wr,
    output logic [1:0]  dev_size,
    output logic [3:0]  dev_wstrb,
    output logic [31:0] dev_addr,
    output logic [31:0] dev_wdata,
    input  logic        dev_addr_ok,
    input  logic        dev_data_ok,
    input  logic [31:0] dev_rdata,

    output logic        resp_err
);

    localparam logic [2:0] MAX_C = 3'(MAX_OUTST);

    // Owner encoding throughout: 1 = inst side, 0 = data side.
    logic [2:0]           occ_q, occ_d;
    logic [MAX_OUTST-1:0] owner_q, owner_d;   // bit 0 is the FIFO head
    logic                 lock_q, lock_d;
    logic                 lock_inst_q, lock_inst_d;
    logic                 last_inst_q, last_inst_d;
    logic                 resp_err_q, resp_err_d;

    logic       grant_inst;
    logic       cap_ok;
    logic       accept;
    logic       ret_valid;
    logic [2:0] push_idx;

    always_comb begin
        grant_inst = 1'b0;
        // A held grant only applies while its owner is still requesting;
        // otherwise fall back to normal selection so dev_* never carries
        // the fields of an idle requester.
        if (lock_q && (lock_inst_q ? inst_req : data_req)) begin
            grant_inst = lock_inst_q;
        end else if (inst_req && !data_req) begin
            grant_inst = 1'b1;
        end else if (data_req && !inst_req) begin
            grant_inst = 1'b0;
        end else begin
            grant_inst = !last_inst_q;
        end

        // A full FIFO still accepts when a return frees a slot this cycle.
        cap_ok    = (occ_q < MAX_C) || ((occ_q == MAX_C) && dev_data_ok);
        dev_req   = (inst_req || data_req) && cap_ok;
        accept    = dev_req && dev_addr_ok;
        ret_valid = dev_data_ok && (occ_q != 3'd0);

        dev_wr    = grant_inst ? inst_wr    : data_wr;
        dev_size  = grant_inst ? inst_size  : data_size;
        dev_addr  = grant_inst ? inst_addr  : data_addr;
        dev_wdata = grant_inst ? inst_wdata : data_wdata;
        dev_wstrb = dev_req ? (grant_inst ? inst_wstrb : data_wstrb) : 4'b0000;

        inst_addr_ok = accept && grant_inst;
        data_addr_ok = accept && !grant_inst;
        inst_data_ok = ret_valid && owner_q[0];
        data_data_ok = ret_valid && !owner_q[0];
        inst_rdata   = dev_rdata;
        data_rdata   = dev_rdata;
        resp_err     = resp_err_q;

        occ_d = occ_q + {2'b00, accept} - {2'b00, ret_valid};

        // Pop shifts the old head out first; the push slot is computed from
        // the post-pop fill level so a same-cycle push never gets popped.
        owner_d  = ret_valid ? (owner_q >> 1) : owner_q;
        push_idx = occ_q - {2'b00, ret_valid};
        for (int i = 0; i < MAX_OUTST; i++) begin
            if (accept && (3'(i) == push_idx)) begin
                owner_d[i] = grant_inst;
            end
        end

        lock_d      = dev_req && !dev_addr_ok;
        lock_inst_d = grant_inst;
        last_inst_d = accept ? grant_inst : last_inst_q;
        resp_err_d  = resp_err_q || (dev_data_ok && (occ_q == 3'd0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q       <= 3'd0;
            owner_q     <= '0;
            lock_q      <= 1'b0;
            lock_inst_q <= 1'b0;
            last_inst_q <= 1'b1;   // data wins the first contention
            resp_err_q  <= 1'b0;
        end else begin
            occ_q       <= occ_d;
            owner_q     <= owner_d;
            lock_q      <= lock_d;
            lock_inst_q <= lock_inst_d;
            last_inst_q <= last_inst_d;
            resp_err_q  <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
module tb_sram_req_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size, dev_size;
    logic [3:0]  inst_wstrb, data_wstrb, dev_wstrb;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        dev_req, dev_wr, dev_addr_ok, dev_data_ok;
    logic [31:0] dev_addr, dev_wdata, dev_rdata;
    logic        resp_err;

    int n_checks = 0;
    int n_fail   = 0;

    // {dev_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}
    logic [4:0] hs;
    assign hs = {dev_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok};

    localparam logic [31:0] IA = 32'h0000_0100;
    localparam logic [31:0] DA = 32'h0000_0200;

    sram_req_arbiter #(.MAX_OUTST(2)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .dev_req(dev_req), .dev_wr(dev_wr), .dev_size(dev_size), .dev_wstrb(dev_wstrb),
        .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_addr_ok(dev_addr_ok),
        .dev_data_ok(dev_data_ok), .dev_rdata(dev_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    // Inputs change just after the falling edge; checks run #1 later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic drive(input logic ir, input logic dr, input logic aok, input logic dok);
        inst_req    = ir;
        data_req    = dr;
        dev_addr_ok = aok;
        dev_data_ok = dok;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0);
        inst_wr = 0; data_wr = 1;
        inst_size = 2'd2; data_size = 2'd1;
        inst_wstrb = 4'h3; data_wstrb = 4'hc;
        inst_addr = IA; data_addr = DA;
        inst_wdata = 32'h1111_1111; data_wdata = 32'h2222_2222;
        dev_rdata = 32'h0;
        next_cycle(); next_cycle();
        #1;
        n_checks++;
        if (hs !== 5'b00000 || resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_active: hs=%b err=%b want hs=00000 err=0", hs, resp_err);
        end
        next_cycle();
        reset = 1'b0;
        #1;
        n_checks++;
        if (hs !== 5'b00000 || dev_wstrb !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_first_cycle: hs=%b wstrb=%h want hs=00000 wstrb=0", hs, dev_wstrb);
        end
        next_cycle();
    endtask

    // Both sides requesting: grants alternate data, inst, data; returns
    // arrive one cycle after each accept and go back to the right owner.
    task automatic test_alternate();
        logic [4:0]  exp_hs [4] = '{5'b10100, 5'b11001, 5'b10110, 5'b00001};
        logic [31:0] exp_a  [4] = '{DA, IA, DA, DA};
        logic        rq     [4] = '{1, 1, 1, 0};
        logic        dk     [4] = '{0, 1, 1, 1};
        for (int c = 0; c < 4; c++) begin
            drive(rq[c], rq[c], 1'b1, dk[c]);
            dev_rdata = 32'hA000_0000 + 32'(c);
            #1;
            n_checks++;
            if (hs !== exp_hs[c]) begin
                n_fail++;
                $display("FAIL alt_hs[%0d]: got %b want %b", c, hs, exp_hs[c]);
            end
            if (rq[c]) begin
                n_checks++;
                if (dev_addr !== exp_a[c] || dev_wr !== (exp_a[c] == DA) ||
                    dev_wstrb !== ((exp_a[c] == DA) ? 4'hc : 4'h3)) begin
                    n_fail++;
                    $display("FAIL alt_fields[%0d]: addr=%h wr=%b strb=%h want addr=%h", c,
                             dev_addr, dev_wr, dev_wstrb, exp_a[c]);
                end
            end
            n_checks++;
            if (inst_rdata !== dev_rdata || data_rdata !== 32'hA000_0000 + 32'(c)) begin
                n_fail++;
                $display("FAIL alt_rdata[%0d]: inst=%h data=%h want %h", c, inst_rdata,
                         data_rdata, 32'hA000_0000 + 32'(c));
            end
            next_cycle();
        end
    endtask

    // Last accept was data. Data request stalls, inst joins: the latched
    // data grant must hold until accepted, then inst wins.
    // Then the FIFO fills (occ=2) and only a return lets a request through.
    task automatic test_lock_and_full();
        logic [4:0]  exp_hs [11] = '{5'b10000, 5'b10000, 5'b10000, 5'b10100, 5'b11000,
                                     5'b00000, 5'b00000, 5'b10101, 5'b00000, 5'b00010,
                                     5'b00001};
        logic [31:0] exp_a  [11] = '{DA, DA, DA, DA, IA, 0, 0, DA, 0, 0, 0};
        logic        ir     [11] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
        logic        dr     [11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
        logic        ak     [11] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0};
        logic        dk     [11] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1};
        for (int c = 0; c < 11; c++) begin
            drive(ir[c], dr[c], ak[c], dk[c]);
            #1;
            n_checks++;
            if (hs !== exp_hs[c]) begin
                n_fail++;
                $display("FAIL lockfull_hs[%0d]: got %b want %b", c, hs, exp_hs[c]);
            end
            if (exp_hs[c][4]) begin
                n_checks++;
                if (dev_addr !== exp_a[c]) begin
                    n_fail++;
                    $display("FAIL lockfull_addr[%0d]: got %h want %h", c, dev_addr, exp_a[c]);
                end
            end else begin
                n_checks++;
                if (dev_wstrb !== 4'h0) begin
                    n_fail++;
                    $display("FAIL lockfull_wstrb[%0d]: got %h want 0", c, dev_wstrb);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_routing();
        inst_addr = 32'h1c00_0000; data_addr = 32'h0000_1000; data_wr = 0;
        drive(1, 0, 1, 0);
        #1;
        n_checks++;
        if (hs !== 5'b11000 || dev_addr !== 32'h1c00_0000) begin
            n_fail++;
            $display("FAIL route_inst_acc: hs=%b addr=%h", hs, dev_addr);
        end
        next_cycle();
        drive(0, 1, 1, 0);
        #1;
        n_checks++;
        if (hs !== 5'b10100 || dev_addr !== 32'h0000_1000 || dev_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL route_data_acc: hs=%b addr=%h wr=%b", hs, dev_addr, dev_wr);
        end
        next_cycle();
        drive(0, 0, 0, 1);
        dev_rdata = 32'hdead_beef;
        #1;
        n_checks++;
        if (hs !== 5'b00010 || inst_rdata !== 32'hdead_beef) begin
            n_fail++;
            $display("FAIL route_inst_ret: hs=%b rdata=%h want 00010 deadbeef", hs, inst_rdata);
        end
        next_cycle();
        dev_rdata = 32'h1234_5678;
        #1;
        n_checks++;
        if (hs !== 5'b00001 || data_rdata !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL route_data_ret: hs=%b rdata=%h want 00001 12345678", hs, data_rdata);
        end
        next_cycle();
        inst_addr = IA; data_addr = DA; data_wr = 1;
    endtask

    task automatic test_stray();
        drive(0, 0, 0, 1);
        #1;
        n_checks++;
        if (hs !== 5'b00000 || resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_pulse: hs=%b err=%b want 00000 0", hs, resp_err);
        end
        next_cycle();
        drive(0, 1, 1, 0);
        #1;
        n_checks++;
        if (resp_err !== 1'b1 || hs !== 5'b10100) begin
            n_fail++;
            $display("FAIL stray_err_set: err=%b hs=%b want 1 10100", resp_err, hs);
        end
        next_cycle();
        drive(0, 0, 0, 1);
        #1;
        n_checks++;
        if (hs !== 5'b00001) begin
            n_fail++;
            $display("FAIL stray_occ_intact: hs=%b want 00001", hs);
        end
        next_cycle();
        drive(0, 0, 0, 0);
        #1;
        n_checks++;
        if (resp_err !== 1'b1) begin
            n_fail++;
            $display("FAIL stray_err_sticky: err=%b want 1", resp_err);
        end
        next_cycle();
    endtask

    // occ=2 plus an inst lock, then reset: ownership and lock are dropped.
    task automatic test_reset_mid();
        drive(1, 0, 1, 0); next_cycle();
        drive(0, 1, 1, 0); next_cycle();
        drive(1, 1, 1, 1); next_cycle();    // return inst, accept inst; occ 2
        drive(1, 0, 0, 0);
        #1;
        n_checks++;
        if (hs !== 5'b00000) begin
            n_fail++;
            $display("FAIL mid_full: hs=%b want 00000", hs);
        end
        next_cycle();
        drive(1, 0, 0, 1);                   // return data; inst stalls -> lock inst
        #1;
        n_checks++;
        if (hs !== 5'b10001 || dev_addr !== IA) begin
            n_fail++;
            $display("FAIL mid_lock: hs=%b addr=%h want 10001 %h", hs, dev_addr, IA);
        end
        next_cycle();
        reset = 1'b1;
        drive(1, 1, 0, 0);
        next_cycle();
        reset = 1'b0;
        drive(0, 0, 0, 1);
        #1;
        n_checks++;
        if (hs !== 5'b00000 || resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_discard: hs=%b err=%b want 00000 0", hs, resp_err);
        end
        next_cycle();
        drive(1, 1, 1, 0);
        #1;
        n_checks++;
        if (hs !== 5'b10100 || dev_addr !== DA || resp_err !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_after: hs=%b addr=%h err=%b want 10100 %h 1", hs, dev_addr,
                     resp_err, DA);
        end
        next_cycle();
        drive(0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_lock_and_full();
        test_routing();
        test_stray();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
